// File: rtl/load_store_unit_if.sv
// Pipeline request/response and data-memory port bundle for load_store_unit.
// slave is the LSU side; master is the pipeline/memory side that drives it.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
    output req_ready, resp_valid, resp_rdata, resp_fault, mem_A, mem_WD, mem_WE
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
    input  req_ready, resp_valid, resp_rdata, resp_fault, mem_A, mem_WD, mem_WE
  );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store controller: word accesses, sub-word extract/extend, RMW stores.
// Optional macro LSU_ALIGN_CHECK_EN enables misaligned-access faults.
module load_store_unit (
  input  logic             CLK,
  input  logic             RST,
  load_store_unit_if.slave lsu
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LD     = 3'd1;
  localparam logic [2:0] ST_RMW_RD = 3'd2;
  localparam logic [2:0] ST_WR     = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  logic [2:0]  state_r;
  logic [2:0]  funct3_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] merge_r;
  logic [31:0] resp_rdata_r;
  logic        resp_fault_r;
  logic        illegal_s;
  logic        misalign_s;
  logic        fault_s;

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] lane);
    case (lane)
      2'd0:    pick_byte = w[7:0];
      2'd1:    pick_byte = w[15:8];
      2'd2:    pick_byte = w[23:16];
      default: pick_byte = w[31:24];
    endcase
  endfunction

  // Halfword lane uses addr[1] only, so addr[0] is effectively forced to zero.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = pick_byte(w, lane);
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    load_extract = {{24{b[7]}}, b};
      F3_H:    load_extract = {{16{h[15]}}, h};
      F3_W:    load_extract = w;
      F3_BU:   load_extract = {24'h000000, b};
      F3_HU:   load_extract = {16'h0000, h};
      default: load_extract = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] w, input logic [31:0] d);
    logic [31:0] m;
    m = w;
    case (f3)
      F3_B: begin
        case (lane)
          2'd0:    m[7:0]   = d[7:0];
          2'd1:    m[15:8]  = d[7:0];
          2'd2:    m[23:16] = d[7:0];
          default: m[31:24] = d[7:0];
        endcase
      end
      F3_H: begin
        if (lane[1]) begin
          m[31:16] = d[15:0];
        end else begin
          m[15:0] = d[15:0];
        end
      end
      default: m = d;
    endcase
    return m;
  endfunction

  // Illegal funct3 decode for the request presented in IDLE.
  always_comb begin
    illegal_s = 1'b0;
    if (lsu.req_we) begin
      illegal_s = (lsu.req_funct3 > 3'd2);
    end else begin
      case (lsu.req_funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: illegal_s = 1'b0;
        default:                        illegal_s = 1'b1;
      endcase
    end
  end

`ifdef LSU_ALIGN_CHECK_EN
  // Misalignment decode; store codes SH/SW share the LH/LW encodings.
  always_comb begin
    misalign_s = 1'b0;
    case (lsu.req_funct3)
      F3_H, F3_HU: misalign_s = lsu.req_addr[0];
      F3_W:        misalign_s = |lsu.req_addr[1:0];
      default:     misalign_s = 1'b0;
    endcase
  end
`else
  // No alignment checking in this build.
  always_comb begin
    misalign_s = 1'b0;
  end
`endif

  assign fault_s = illegal_s | misalign_s;

  // Control FSM with request latches, merge register and response registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      funct3_r     <= 3'd0;
      addr_r       <= 32'h0000_0000;
      wdata_r      <= 32'h0000_0000;
      merge_r      <= 32'h0000_0000;
      resp_rdata_r <= 32'h0000_0000;
      resp_fault_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (lsu.req_valid) begin
            funct3_r <= lsu.req_funct3;
            addr_r   <= lsu.req_addr;
            wdata_r  <= lsu.req_wdata;
            if (fault_s) begin
              resp_rdata_r <= 32'h0000_0000;
              resp_fault_r <= 1'b1;
              state_r      <= ST_RESP;
            end else if (!lsu.req_we) begin
              state_r <= ST_LD;
            end else if (lsu.req_funct3 == F3_W) begin
              state_r <= ST_WR;
            end else begin
              state_r <= ST_RMW_RD;
            end
          end
        end
        ST_LD: begin
          resp_rdata_r <= load_extract(funct3_r, addr_r[1:0], lsu.mem_RD);
          resp_fault_r <= 1'b0;
          state_r      <= ST_RESP;
        end
        ST_RMW_RD: begin
          merge_r <= store_merge(funct3_r, addr_r[1:0], lsu.mem_RD, wdata_r);
          state_r <= ST_WR;
        end
        ST_WR: begin
          resp_rdata_r <= 32'h0000_0000;
          resp_fault_r <= 1'b0;
          state_r      <= ST_RESP;
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Port outputs decoded purely from registered state so mem_WE cannot glitch.
  always_comb begin
    lsu.req_ready  = (state_r == ST_IDLE);
    lsu.resp_valid = (state_r == ST_RESP);
    lsu.resp_rdata = resp_rdata_r;
    lsu.resp_fault = resp_fault_r;
    lsu.mem_WE     = (state_r == ST_WR);
    if ((state_r == ST_LD) || (state_r == ST_RMW_RD) || (state_r == ST_WR)) begin
      lsu.mem_A = {addr_r[31:2], 2'b00};
    end else begin
      lsu.mem_A = 32'h0000_0000;
    end
    if (state_r == ST_WR) begin
      lsu.mem_WD = (funct3_r == F3_W) ? wdata_r : merge_r;
    end else begin
      lsu.mem_WD = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small word memory model.
module tb_load_store_unit;

  logic CLK = 1'b0;
  logic RST;
  logic mem_init;

  load_store_unit_if bus();

  load_store_unit dut (
    .CLK (CLK),
    .RST (RST),
    .lsu (bus)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [0:15];
  int          we_cnt;
  logic [31:0] last_wa;
  int          total = 0;
  int          bad   = 0;
  int          lat;
  int          pulses;
  int          acc;
  int          low;
  int          we0;
  logic [31:0] rd;
  logic        flt;

  assign bus.mem_RD = mem[bus.mem_A[5:2]];

  // Memory model: commits on every rising edge while mem_WE is high.
  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0000_0000;
      mem[0]  <= 32'h0000_05E8;
      mem[1]  <= 32'h0000_067F;
      we_cnt  <= 0;
      last_wa <= 32'h0000_0000;
    end else if (bus.mem_WE) begin
      mem[bus.mem_A[5:2]] <= bus.mem_WD;
      we_cnt  <= we_cnt + 1;
      last_wa <= bus.mem_A;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request: lat = negedges after the accept edge until resp_valid (0 = no response).
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    @(negedge CLK);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    @(posedge CLK);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'hFFFF_FFFF;
    bus.req_wdata = ~d;
    lat    = 0;
    pulses = 0;
    rd     = 32'h0000_0000;
    flt    = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      if (bus.resp_valid) begin
        pulses++;
        if (lat == 0) begin
          lat = k;
          rd  = bus.resp_rdata;
          flt = bus.resp_fault;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST            = 1'b1;
    mem_init       = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'h0000_0000;
    bus.req_wdata  = 32'h0000_0000;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rvalid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'h0000_0000);
    chk("rst_fault", {31'd0, bus.resp_fault}, 32'd0);
    chk("rst_memA", bus.mem_A, 32'h0000_0000);
    chk("rst_memWD", bus.mem_WD, 32'h0000_0000);
    chk("rst_memWE", {31'd0, bus.mem_WE}, 32'd0);
    mem_init = 1'b0;
    RST      = 1'b0;

    // Load extension.
    issue(1'b0, 3'd0, 32'd0, 32'd0);
    chk("lb0_lat", lat, 32'd2);
    chk("lb0_data", rd, 32'hFFFF_FFE8);
    chk("lb0_fault", {31'd0, flt}, 32'd0);
    chk("lb0_pulses", pulses, 32'd1);
    issue(1'b0, 3'd4, 32'd0, 32'd0);
    chk("lbu0_data", rd, 32'h0000_00E8);
    issue(1'b0, 3'd1, 32'd4, 32'd0);
    chk("lh4_data", rd, 32'h0000_067F);
    issue(1'b0, 3'd0, 32'd5, 32'd0);
    chk("lb5_data", rd, 32'h0000_0006);

    // Word store then readback, including upper-halfword extension.
    we0 = we_cnt;
    issue(1'b1, 3'd2, 32'd8, 32'hDEAD_BEEF);
    chk("sw8_lat", lat, 32'd2);
    chk("sw8_rdata", rd, 32'h0000_0000);
    chk("sw8_we_cycles", we_cnt - we0, 32'd1);
    chk("sw8_waddr", last_wa, 32'd8);
    chk("sw8_mem", mem[2], 32'hDEAD_BEEF);
    issue(1'b0, 3'd2, 32'd8, 32'd0);
    chk("lw8_lat", lat, 32'd2);
    chk("lw8_data", rd, 32'hDEAD_BEEF);
    chk("lw8_hold", bus.resp_rdata, 32'hDEAD_BEEF);
    issue(1'b0, 3'd1, 32'd10, 32'd0);
    chk("lh10_data", rd, 32'hFFFF_DEAD);
    issue(1'b0, 3'd5, 32'd10, 32'd0);
    chk("lhu10_data", rd, 32'h0000_DEAD);

    // Sub-word read-modify-write stores.
    we0 = we_cnt;
    issue(1'b1, 3'd0, 32'd5, 32'h1234_56AA);
    chk("sb5_lat", lat, 32'd3);
    chk("sb5_we_cycles", we_cnt - we0, 32'd1);
    chk("sb5_waddr", last_wa, 32'd4);
    chk("sb5_mem", mem[1], 32'h0000_AA7F);
    issue(1'b1, 3'd1, 32'd6, 32'h0000_BEEF);
    chk("sh6_lat", lat, 32'd3);
    chk("sh6_mem", mem[1], 32'hBEEF_AA7F);

    // Misaligned word load.
    we0 = we_cnt;
    issue(1'b0, 3'd2, 32'd2, 32'd0);
`ifdef LSU_ALIGN_CHECK_EN
    chk("lw2_lat", lat, 32'd1);
    chk("lw2_fault", {31'd0, flt}, 32'd1);
    chk("lw2_data", rd, 32'h0000_0000);
`else
    chk("lw2_lat", lat, 32'd2);
    chk("lw2_fault", {31'd0, flt}, 32'd0);
    chk("lw2_data", rd, 32'h0000_05E8);
`endif
    chk("lw2_no_write", we_cnt - we0, 32'd0);

    // Illegal funct3.
    we0 = we_cnt;
    issue(1'b1, 3'd3, 32'd0, 32'hFFFF_FFFF);
    chk("st3_lat", lat, 32'd1);
    chk("st3_fault", {31'd0, flt}, 32'd1);
    chk("st3_data", rd, 32'h0000_0000);
    chk("st3_no_write", we_cnt - we0, 32'd0);
    chk("st3_mem0", mem[0], 32'h0000_05E8);
    issue(1'b0, 3'd6, 32'd0, 32'd0);
    chk("ld6_fault", {31'd0, flt}, 32'd1);

    // Back-to-back LW with req_valid held.
    @(negedge CLK);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd2;
    bus.req_addr   = 32'd0;
    acc    = 0;
    low    = 0;
    pulses = 0;
    rd     = 32'h0000_0000;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge CLK);
      if (bus.resp_valid) begin
        pulses++;
        rd = bus.resp_rdata;
      end
      if (bus.req_ready && bus.req_valid) begin
        acc++;
        if (acc == 2) begin
          @(posedge CLK);
          #1 bus.req_valid = 1'b0;
        end
      end else if ((acc == 1) && !bus.req_ready) begin
        low++;
      end
    end
    bus.req_valid = 1'b0;
    chk("b2b_accepts", acc, 32'd2);
    chk("b2b_pulses", pulses, 32'd2);
    chk("b2b_ready_low", low, 32'd2);
    chk("b2b_data", rd, 32'h0000_05E8);

    // Reset while the SB is in RMW_RD.
    we0 = we_cnt;
    @(negedge CLK);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'h0000_00FF;
    @(posedge CLK);
    #1;
    bus.req_valid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    chk("mrst_memWE", {31'd0, bus.mem_WE}, 32'd0);
    chk("mrst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("mrst_rvalid", {31'd0, bus.resp_valid}, 32'd0);
    chk("mrst_rdata", bus.resp_rdata, 32'h0000_0000);
    chk("mrst_fault", {31'd0, bus.resp_fault}, 32'd0);
    chk("mrst_memA", bus.mem_A, 32'h0000_0000);
    chk("mrst_memWD", bus.mem_WD, 32'h0000_0000);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("mrst_no_write", we_cnt - we0, 32'd0);
    chk("mrst_mem0", mem[0], 32'h0000_05E8);
    chk("mrst_idle_ready", {31'd0, bus.req_ready}, 32'd1);
    issue(1'b0, 3'd2, 32'd0, 32'd0);
    chk("post_rst_lw", rd, 32'h0000_05E8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side controller for the word-addressed data memory, sitting in the MEM stage between the pipeline and the data memory port. It accepts one load or store request at a time, issues word accesses on the memory port and performs byte/halfword extraction with sign/zero extension. It also does read-modify-write merging for sub-word stores, and reports completion and faults back to the pipeline.

## Interface
Parameters:
- None. Memory port width is fixed at 32 bits. Byte addresses are converted to word-aligned addresses.

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  asynchronous, active-high reset
- req_valid  in  1  pipeline presents a request
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: loads 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; stores 0 SB, 1 SH, 2 SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_fault  out  1  valid with resp_valid: misaligned or illegal funct3
- mem_A  out  32  {addr[31:2],2'b00}
- mem_WD  out  32  write word
- mem_WE  out  1  write enable; memory commits while high
- mem_RD  in  32  combinational read word for mem_A

## Operation
- States: IDLE, LD, RMW_RD, WR, RESP.
- IDLE: req_ready=1. On req_valid, latch we, funct3, addr, wdata.
- Transitions out of IDLE:
  - Fault → RESP
  - Load → LD
  - SW → WR
  - SB/SH → RMW_RD
- LD: drive mem_A. Capture mem_RD, then extract:
  - Byte lane is addr[1:0]; halfword lane is addr[1].
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
  - Result goes to the resp_rdata register → RESP.
- RMW_RD: drive mem_A and capture mem_RD into a merge register.
  - SB replaces byte addr[1:0] with wdata[7:0].
  - SH replaces halfword addr[1] with wdata[15:0].
  - Then → WR.
- WR: mem_WE=1 for exactly one cycle.
  - mem_WD = wdata for SW, the merged word for SB/SH.
  - Then → RESP.
- RESP: resp_valid=1 for one cycle → IDLE. resp_rdata/resp_fault hold until the next RESP.
- Faults:
  - Illegal funct3: load 3/6/7; store ≥3.
  - Misaligned (see Configuration).
  - On a fault there is no memory access: mem_WE stays 0.
- mem_WE is decoded only from the state register, so it is glitch-free. It is 0 in every state except WR.
- mem_A is 0 in IDLE and RESP.

## Timing
- Request accepted at edge N (IDLE, req_valid=1). resp_valid is high in the cycle after:
  - Fault: edge N+1
  - Load, SW: edge N+2
  - SB/SH: edge N+3
- Back-to-back throughput: the next request is accepted at the edge ending RESP.
- req_valid is ignored outside IDLE. Inputs need only be stable at the accept edge.
- Reset values:
  - state=IDLE, req_ready=1
  - resp_valid=0, resp_rdata=0, resp_fault=0
  - mem_A=0, mem_WD=0, mem_WE=0
- Reset mid-operation:
  - Asynchronous return to IDLE.
  - mem_WE drops immediately. No partial or deferred write occurs.
  - A store interrupted in RMW_RD leaves memory unchanged.
- Simultaneous RST and req_valid: reset wins and the request is dropped.

## Configuration
- LSU_ALIGN_CHECK_EN defined:
  - LH/LHU/SH with addr[0]≠0 → fault.
  - LW/SW with addr[1:0]≠0 → fault.
- Undefined:
  - No alignment checking; the sub-word offset bits are forced to zero before lane selection, so halfword accesses use addr[1] only and word accesses ignore addr[1:0].
  - Illegal funct3 still faults.

## Test plan
All scenarios start with memory word0=0x000005E8, word1=0x0000067F.
- Load extension: LB addr 0 → resp_rdata 0xFFFFFFE8 at N+2; LBU addr 0 → 0x000000E8; LH addr 4 → 0x0000067F; LB addr 5 → 0x00000006.
- SW addr 8 wdata 0xDEADBEEF → mem_WE high exactly one cycle with mem_A=8; resp at N+2; then LW addr 8 → 0xDEADBEEF.
- RMW stores:
  - SB addr 5 wdata 0x123456AA → resp at N+3, word1 becomes 0x0000AA7F.
  - Then SH addr 6 wdata 0xBEEF → word1 = 0xBEEFAA7F.
- Misaligned access: LW addr 2.
  - With LSU_ALIGN_CHECK_EN: resp_fault=1 and resp_rdata=0 at N+1, mem_WE never asserted.
  - Without it: resp_rdata 0x000005E8 at N+2.
- Illegal funct3 and back-to-back: store funct3=3 → fault at N+1 with no write. Two back-to-back LW requests held on req_valid → two resp pulses, req_ready low between them.
- Reset mid-op: assert RST during RMW_RD of SB addr 0 wdata 0xFF → mem_WE never high, word0 stays 0x000005E8, outputs at reset values, req_ready=1.
